// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by the fetch/decode front end.
// Opcodes, ext codes, flag_type codes and fetch-state encoding.
package cpu_isa_pkg;

   localparam logic [3:0] OP_RTYPE  = 4'b0000;
   localparam logic [3:0] OP_LDST   = 4'b0100;
   localparam logic [3:0] OP_SHIFT  = 4'b1000;
   localparam logic [3:0] OP_BCOND  = 4'b1100;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;

   localparam logic [3:0] FT_NONE   = 4'b0000;
   localparam logic [3:0] FT_ALU    = 4'b0001;
   localparam logic [3:0] FT_LOAD   = 4'b0010;
   localparam logic [3:0] FT_STORE  = 4'b0100;
   localparam logic [3:0] FT_BRANCH = 4'b1000;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_FETCH   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_ISSUE   = 2'd3;

   // Immediate-form ALU opcodes: 0001 0010 0011 0101 1001 1011 1101 1111
   function automatic logic is_imm_op(input logic [3:0] op);
      return (op == 4'b0001) || (op == 4'b0010) ||
             (op == 4'b0011) || (op == 4'b0101) ||
             (op == 4'b1001) || (op == 4'b1011) ||
             (op == 4'b1101) || (op == 4'b1111);
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one 16-bit instruction word.
// In: i_ir. Out: opcode, one-hot rdst, rsrc, imm, cond, flag, illegal.
module instr_decoder
   import cpu_isa_pkg::*;
(
   input  logic [15:0] i_ir,
   output logic [7:0]  o_opcode,
   output logic [15:0] o_rdst,
   output logic [4:0]  o_rsrc,
   output logic [7:0]  o_imm,
   output logic [3:0]  o_cond,
   output logic [3:0]  o_flag,
   output logic        o_illegal
);

   logic [3:0] w_op;
   logic [3:0] w_ext;
   logic [3:0] w_rd;

   assign w_op  = i_ir[15:12];
   assign w_ext = i_ir[7:4];
   assign w_rd  = i_ir[11:8];

   always_comb begin
      o_opcode  = 8'h00;
      o_rdst    = 16'h0000;
      o_rsrc    = 5'd0;
      o_imm     = 8'h00;
      o_cond    = 4'h0;
      o_flag    = FT_NONE;
      o_illegal = 1'b0;
      unique case (1'b1)
         (w_op == OP_RTYPE): begin
            o_opcode = {w_op, w_ext};
            o_rdst   = 16'h0001 << w_rd;
            o_rsrc   = {1'b0, i_ir[3:0]};
            o_flag   = FT_ALU;
         end
         (is_imm_op(w_op) || w_op == OP_SHIFT): begin
            o_opcode = {w_op, 4'b0000};
            o_rdst   = 16'h0001 << w_rd;
            o_imm    = i_ir[7:0];
            o_flag   = FT_ALU;
         end
         (w_op == OP_LDST && w_ext == EXT_LOAD): begin
            o_opcode = {w_op, w_ext};
            o_rdst   = 16'h0001 << w_rd;
            o_rsrc   = {1'b0, i_ir[3:0]};
            o_flag   = FT_LOAD;
         end
         // rdst carries the store-data register; the write is
         // suppressed downstream
         (w_op == OP_LDST && w_ext == EXT_STOR): begin
            o_opcode = {w_op, w_ext};
            o_rdst   = 16'h0001 << w_rd;
            o_rsrc   = {1'b0, i_ir[3:0]};
            o_flag   = FT_STORE;
         end
         (w_op == OP_LDST && w_ext == EXT_JCOND): begin
            o_opcode = {w_op, w_ext};
            o_rsrc   = {1'b0, i_ir[3:0]};
            o_cond   = w_rd;
            o_flag   = FT_BRANCH;
         end
         (w_op == OP_BCOND): begin
            o_opcode = {w_op, 4'b0000};
            o_imm    = i_ir[7:0];
            o_cond   = w_rd;
            o_flag   = FT_BRANCH;
         end
         default: begin
            o_illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// Front end: owns PC, fetches from sync RAM, decodes, issues under
// valid/ack. Ports: clk/reset, mem_*, instr_valid/ack, pc_*, fields.
module instr_fetch_decode
   import cpu_isa_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [15:0]       mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ack,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   output logic [ADDR_W-1:0] pc_out,
   output logic [7:0]        opcode_out,
   output logic [15:0]       rdst_out,
   output logic [4:0]        rsrc_out,
   output logic [7:0]        immediate_out,
   output logic [3:0]        cond_out,
   output logic [3:0]        flag_type,
   output logic              illegal
);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_pc_out;
   logic [7:0]        r_opcode;
   logic [15:0]       r_rdst;
   logic [4:0]        r_rsrc;
   logic [7:0]        r_imm;
   logic [3:0]        r_cond;
   logic [3:0]        r_flag;
   logic              r_illegal;

   logic [7:0]        w_opcode;
   logic [15:0]       w_rdst;
   logic [4:0]        w_rsrc;
   logic [7:0]        w_imm;
   logic [3:0]        w_cond;
   logic [3:0]        w_flag;
   logic              w_illegal;
   logic [ADDR_W-1:0] w_pc_inc;

   instr_decoder u_dec (
      .i_ir      (mem_rdata),
      .o_opcode  (w_opcode),
      .o_rdst    (w_rdst),
      .o_rsrc    (w_rsrc),
      .o_imm     (w_imm),
      .o_cond    (w_cond),
      .o_flag    (w_flag),
      .o_illegal (w_illegal)
   );

   // natural wrap from all-ones back to zero
   assign w_pc_inc = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pc      <= RESET_PC;
         r_pc_out  <= '0;
         r_opcode  <= '0;
         r_rdst    <= '0;
         r_rsrc    <= '0;
         r_imm     <= '0;
         r_cond    <= '0;
         r_flag    <= '0;
         r_illegal <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE:  r_state <= S_FETCH;
            S_FETCH: r_state <= S_WAIT;
            S_WAIT: begin
               r_opcode  <= w_opcode;
               r_rdst    <= w_rdst;
               r_rsrc    <= w_rsrc;
               r_imm     <= w_imm;
               r_cond    <= w_cond;
               r_flag    <= w_flag;
               r_illegal <= w_illegal;
               r_pc_out  <= r_pc;
               r_state   <= S_ISSUE;
            end
            S_ISSUE: begin
               if (instr_ack) begin
                  r_pc    <= pc_load ? pc_target : w_pc_inc;
                  r_state <= S_FETCH;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_addr      = r_pc;
   assign mem_rd        = (r_state == S_FETCH);
   assign instr_valid   = (r_state == S_ISSUE);
   assign pc_out        = r_pc_out;
   assign opcode_out    = r_opcode;
   assign rdst_out      = r_rdst;
   assign rsrc_out      = r_rsrc;
   assign immediate_out = r_imm;
   assign cond_out      = r_cond;
   assign flag_type     = r_flag;
   assign illegal       = r_illegal;

endmodule
